ps2_key_decoder: RTL and testbench

//   Consumes raw PS/2 set-2 bytes from PS2_Controller (received_data/received_data_en) and feeds the Data stage.

---
 rtl/whac_pkg.sv | 49 ++++
 rtl/key_event_fifo.sv | 61 ++++++
 rtl/ps2_key_decoder.sv | 162 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/whac_pkg.sv
// Shared definitions for the PS/2 keypad front end of the whac-a-mole game.
//   - set-2 scan codes for the prefixes, Space and keypad 1..9
//   - decoder FSM state type
//   - HOLE_W: width of a hole index
//   - sc_to_hole(): maps a keypad make code to {hit, hole index}
package whac_pkg;

  localparam int HOLE_W = 4;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_KP1   = 8'h69;
  localparam logic [7:0] SC_KP2   = 8'h72;
  localparam logic [7:0] SC_KP3   = 8'h7A;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_KP7   = 8'h6C;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP9   = 8'h7D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } key_state_e;

  // Returns {hit, idx}; hit=0 for any code that is not a keypad digit.
  function automatic logic [HOLE_W:0] sc_to_hole(input logic [7:0] sc);
    logic [HOLE_W:0] r;
    r = '0;
    case (sc)
      SC_KP1:  r = {1'b1, 4'd0};
      SC_KP2:  r = {1'b1, 4'd1};
      SC_KP3:  r = {1'b1, 4'd2};
      SC_KP4:  r = {1'b1, 4'd3};
      SC_KP5:  r = {1'b1, 4'd4};
      SC_KP6:  r = {1'b1, 4'd5};
      SC_KP7:  r = {1'b1, 4'd6};
      SC_KP8:  r = {1'b1, 4'd7};
      SC_KP9:  r = {1'b1, 4'd8};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small show-ahead FIFO for hole-hit events.
// Ports:
//   clk, reset_m   clock, asynchronous active-low reset
//   push, wdata    write request and data; accepted when not full, or when a
//                  pop happens in the same cycle (the freed slot is reused)
//   pop            read request; ignored while empty
//   full, empty    occupancy flags
//   head           entry at the read pointer (valid only when !empty)
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_m,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_m) begin
    if (!reset_m) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte decoder: keypad 1..9 -> hole events, Space -> start pulse.
// Optional feature macro: REPEAT_FILTER_EN (held-key mask suppressing
// typematic repeats). Default build has no mask.
// Ports:
//   clk, reset_m      clock, asynchronous active-low reset
//   i_data, i_data_en PS/2 byte and its one-cycle valid strobe
//   o_hole_valid      event FIFO head valid
//   o_hole_idx        hole index at FIFO head
//   i_hole_ready      consumer accept
//   o_start_pulse     one-cycle pulse after a Space make
//   o_drop_cnt        saturating count of events lost to a full FIFO
//
// state      | meaning
// ST_IDLE    | no prefix pending; make codes act here
// ST_BRK     | F0 seen; next byte is a release
// ST_EXT     | E0 seen; next byte is an extended key (ignored)
// ST_EXT_BRK | E0 F0 seen; next byte is an extended release (ignored)
module ps2_key_decoder
  import whac_pkg::*;
#(
  parameter int NUM_HOLES      = 9,
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              reset_m,
  input  logic [7:0]        i_data,
  input  logic              i_data_en,
  output logic              o_hole_valid,
  output logic [HOLE_W-1:0] o_hole_idx,
  input  logic              i_hole_ready,
  output logic              o_start_pulse,
  output logic [7:0]        o_drop_cnt
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  key_state_e        state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              start_q, start_d;
  logic [7:0]        drop_q, drop_d;
  logic [HOLE_W-1:0] idx_last_q;

  logic [HOLE_W:0]   map;
  logic              hit;
  logic [HOLE_W-1:0] idx;
  logic              tmo_hit;
  logic              make_evt;
  logic              push;
  logic              fifo_full, fifo_empty;
  logic [HOLE_W-1:0] fifo_head;

  assign map = sc_to_hole(i_data);
  assign idx = map[HOLE_W-1:0];
  // Narrower builds (NUM_HOLES < 9) simply ignore the upper keypad digits.
  assign hit = map[HOLE_W] && (32'(idx) < NUM_HOLES);

  // Counter is loaded on every accepted byte that leaves the FSM in a
  // prefix state, so zero here means PREFIX_TIMEOUT-1 idle cycles elapsed.
  assign tmo_hit  = (state_q != ST_IDLE) && (tmo_q == '0) && !i_data_en;
  assign make_evt = i_data_en && (state_q == ST_IDLE) && hit;

  // State register
  always_ff @(posedge clk or negedge reset_m) begin
    if (!reset_m) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (i_data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_data == SC_EXT)      state_d = ST_EXT;
          else if (i_data == SC_BRK) state_d = ST_BRK;
        end
        ST_EXT:  state_d = (i_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (state_d == ST_IDLE)      tmo_d = '0;
    else if (i_data_en)          tmo_d = TW'(PREFIX_TIMEOUT - 1);
    else if (tmo_q != '0)        tmo_d = tmo_q - TW'(1);
  end

`ifdef REPEAT_FILTER_EN
  logic [NUM_HOLES-1:0] held_q, held_d;
  logic [NUM_HOLES-1:0] hole_mask;

  assign hole_mask = NUM_HOLES'(1) << idx;

  // Outputs / datapath updates
  always_comb begin
    held_d = held_q;
    push   = make_evt && ((held_q & hole_mask) == '0);
    // A make sets held even when the FIFO drops it, so a held key that
    // was lost does not come back as a repeat.
    if (push) held_d = held_q | hole_mask;
    if (i_data_en && (state_q == ST_BRK) && hit) held_d = held_q & ~hole_mask;
  end

  always_ff @(posedge clk or negedge reset_m) begin
    if (!reset_m) held_q <= '0;
    else          held_q <= held_d;
  end
`else
  // Outputs / datapath updates
  always_comb begin
    push = make_evt;
  end
`endif

  always_comb begin
    start_d = i_data_en && (state_q == ST_IDLE) && (i_data == SC_SPACE);
    drop_d  = drop_q;
    // Full with a simultaneous pop is not a drop: the FIFO reuses the slot.
    if (push && fifo_full && !i_hole_ready && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_m) begin
    if (!reset_m) begin
      tmo_q      <= '0;
      start_q    <= 1'b0;
      drop_q     <= '0;
      idx_last_q <= '0;
    end else begin
      tmo_q   <= tmo_d;
      start_q <= start_d;
      drop_q  <= drop_d;
      if (!fifo_empty) idx_last_q <= fifo_head;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HOLE_W)
  ) u_fifo (
    .clk     (clk),
    .reset_m (reset_m),
    .push    (push),
    .wdata   (idx),
    .pop     (i_hole_ready),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  assign o_hole_valid  = !fifo_empty;
  // Holds the last presented index while the FIFO is empty.
  assign o_hole_idx    = fifo_empty ? idx_last_q : fifo_head;
  assign o_start_pulse = start_q;
  assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset_m = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_data_en = 1'b0;
  logic       o_hole_valid;
  logic [3:0] o_hole_idx;
  logic       i_hole_ready = 1'b0;
  logic       o_start_pulse;
  logic [7:0] o_drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .NUM_HOLES      (9),
    .FIFO_DEPTH     (4),
    .PREFIX_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset_m       (reset_m),
    .i_data        (i_data),
    .i_data_en     (i_data_en),
    .o_hole_valid  (o_hole_valid),
    .o_hole_idx    (o_hole_idx),
    .i_hole_ready  (i_hole_ready),
    .o_start_pulse (o_start_pulse),
    .o_drop_cnt    (o_drop_cnt)
  );

  // Strobe one byte for one cycle; returns 1 time unit after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    i_data    = b;
    i_data_en = 1'b1;
    @(posedge clk); #1;
    i_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_data_en    = 1'b0;
    i_hole_ready = 1'b0;
    reset_m      = 1'b0;
    #3;
    reset_m      = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_m = 1'b0;
    #12;
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", o_hole_valid); end
    checks++; if (o_hole_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0h exp=0", o_hole_idx); end
    checks++; if (o_start_pulse !== 1'b0) begin failures++; $display("FAIL reset_start got=%0h exp=0", o_start_pulse); end
    checks++; if (o_drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0h exp=0", o_drop_cnt); end
    reset_m = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_make();
    do_reset();
    i_hole_ready = 1'b1;
    i_data = 8'h69; i_data_en = 1'b1;
    #2;
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_strobe_cycle got=%0h exp=0", o_hole_valid); end
    @(posedge clk); #1;
    i_data_en = 1'b0;
    checks++; if (o_hole_valid !== 1'b1) begin failures++; $display("FAIL t1_valid_next got=%0h exp=1", o_hole_valid); end
    checks++; if (o_hole_idx !== 4'd0) begin failures++; $display("FAIL t1_idx got=%0h exp=0", o_hole_idx); end
    @(posedge clk); #1;
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t1_popped got=%0h exp=0", o_hole_valid); end
  endtask

  task automatic test_prefixes();
    logic [7:0] seq [10];
    seq = '{8'hF0, 8'h69, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hFA, 8'hAA, 8'hE1};
    do_reset();
    i_hole_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_byte(seq[i]);
      checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t2_no_event byte=%0h got=%0h exp=0", seq[i], o_hole_valid); end
    end
    send_byte(8'h75);
    checks++; if (o_hole_valid !== 1'b1) begin failures++; $display("FAIL t2_kp8_valid got=%0h exp=1", o_hole_valid); end
    checks++; if (o_hole_idx !== 4'd7) begin failures++; $display("FAIL t2_kp8_idx got=%0h exp=7", o_hole_idx); end
    send_byte(8'h29);
    checks++; if (o_start_pulse !== 1'b1) begin failures++; $display("FAIL t2_start got=%0h exp=1", o_start_pulse); end
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t2_space_no_event got=%0h exp=0", o_hole_valid); end
    @(posedge clk); #1;
    checks++; if (o_start_pulse !== 1'b0) begin failures++; $display("FAIL t2_start_one_cycle got=%0h exp=0", o_start_pulse); end
  endtask

  task automatic test_fifo_fill();
    logic [7:0] seq [5];
    logic [3:0] exp_idx [4];
    seq     = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73};
    exp_idx = '{4'd0, 4'd1, 4'd2, 4'd3};
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(seq[i]);
    checks++; if (o_drop_cnt !== 8'd1) begin failures++; $display("FAIL t3_drop got=%0h exp=1", o_drop_cnt); end
    i_hole_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_hole_valid !== 1'b1) begin failures++; $display("FAIL t3_valid[%0d] got=%0h exp=1", i, o_hole_valid); end
      checks++; if (o_hole_idx !== exp_idx[i]) begin failures++; $display("FAIL t3_idx[%0d] got=%0h exp=%0h", i, o_hole_idx, exp_idx[i]); end
      @(posedge clk); #1;
    end
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t3_empty got=%0h exp=0", o_hole_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] seq [4];
    logic [3:0] exp_idx [4];
    seq     = '{8'h72, 8'h7A, 8'h6B, 8'h73};
    exp_idx = '{4'd2, 4'd3, 4'd4, 4'd5};
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(seq[i]);
    checks++; if (o_hole_idx !== 4'd1) begin failures++; $display("FAIL t4_head_before got=%0h exp=1", o_hole_idx); end
    i_data = 8'h74; i_data_en = 1'b1; i_hole_ready = 1'b1;
    @(posedge clk); #1;
    i_data_en = 1'b0; i_hole_ready = 1'b0;
    checks++; if (o_drop_cnt !== 8'd0) begin failures++; $display("FAIL t4_drop_unchanged got=%0h exp=0", o_drop_cnt); end
    checks++; if (o_hole_idx !== 4'd2) begin failures++; $display("FAIL t4_head_after got=%0h exp=2", o_hole_idx); end
    send_byte(8'h69);
    checks++; if (o_drop_cnt !== 8'd1) begin failures++; $display("FAIL t4_still_full got=%0h exp=1", o_drop_cnt); end
    i_hole_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_hole_idx !== exp_idx[i] || o_hole_valid !== 1'b1) begin failures++; $display("FAIL t4_drain[%0d] got=%0h/%0h exp=%0h/1", i, o_hole_idx, o_hole_valid, exp_idx[i]); end
      @(posedge clk); #1;
    end
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t4_empty got=%0h exp=0", o_hole_valid); end
  endtask

  task automatic test_drop_saturate();
    logic [7:0] seq [4];
    seq = '{8'h72, 8'h7A, 8'h6B, 8'h73};
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(seq[i]);
    for (int i = 0; i < 254; i++) begin
      send_byte(8'h69); send_byte(8'hF0); send_byte(8'h69);
    end
    checks++; if (o_drop_cnt !== 8'hFE) begin failures++; $display("FAIL drop_fe got=%0h exp=fe", o_drop_cnt); end
    for (int i = 0; i < 6; i++) begin
      send_byte(8'h69); send_byte(8'hF0); send_byte(8'h69);
    end
    checks++; if (o_drop_cnt !== 8'hFF) begin failures++; $display("FAIL drop_sat got=%0h exp=ff", o_drop_cnt); end
  endtask

  task automatic test_repeat();
    logic [7:0] seq [6];
    int events;
    int exp_events;
    seq = '{8'h73, 8'h73, 8'h73, 8'hF0, 8'h73, 8'h73};
`ifdef REPEAT_FILTER_EN
    exp_events = 2;
`else
    exp_events = 4;
`endif
    events = 0;
    do_reset();
    i_hole_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_byte(seq[i]);
      if (o_hole_valid === 1'b1) begin
        events++;
        checks++; if (o_hole_idx !== 4'd4) begin failures++; $display("FAIL t5_idx[%0d] got=%0h exp=4", i, o_hole_idx); end
      end
    end
    @(posedge clk); #1;
    if (o_hole_valid === 1'b1) events++;
    checks++; if (events != exp_events) begin failures++; $display("FAIL t5_events got=%0d exp=%0d", events, exp_events); end
  endtask

  task automatic test_timeout();
    do_reset();
    i_hole_ready = 1'b1;
    send_byte(8'hF0);
    idle(TMO - 1);
    send_byte(8'h69);
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t6_before_timeout got=%0h exp=0", o_hole_valid); end
    send_byte(8'hF0);
    idle(TMO);
    send_byte(8'h69);
    checks++; if (o_hole_valid !== 1'b1) begin failures++; $display("FAIL t6_after_timeout_valid got=%0h exp=1", o_hole_valid); end
    checks++; if (o_hole_idx !== 4'd0) begin failures++; $display("FAIL t6_after_timeout_idx got=%0h exp=0", o_hole_idx); end
  endtask

  task automatic test_reset_mid_prefix();
    do_reset();
    send_byte(8'h72);
    send_byte(8'hF0);
    checks++; if (o_hole_valid !== 1'b1) begin failures++; $display("FAIL t6b_queued got=%0h exp=1", o_hole_valid); end
    reset_m = 1'b0;
    #2;
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t6b_async_clear got=%0h exp=0", o_hole_valid); end
    #2;
    reset_m = 1'b1;
    @(posedge clk); #1;
    i_hole_ready = 1'b1;
    send_byte(8'h69);
    checks++; if (o_hole_valid !== 1'b1 || o_hole_idx !== 4'd0) begin failures++; $display("FAIL t6b_event got=%0h/%0h exp=1/0", o_hole_valid, o_hole_idx); end
    @(posedge clk); #1;
    checks++; if (o_hole_valid !== 1'b0) begin failures++; $display("FAIL t6b_only_one got=%0h exp=0", o_hole_valid); end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_prefixes();
    test_fifo_fill();
    test_full_push_pop();
    test_drop_saturate();
    test_repeat();
    test_timeout();
    test_reset_mid_prefix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
